// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : alu_arbiter
//  Purpose  : Round-robin sharing of one registered-input ALU between two
//             requesters. One transaction in flight; rejected opcodes are
//             answered with an error response and never reach the ALU.
//  Revision : 1.0  initial release
// ============================================================================
module alu_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [2:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp0_err,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [2:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic              rsp1_err,
  output logic [2:0]        alu_op,
  output logic [DATA_W-1:0] alu_x1,
  output logic [DATA_W-1:0] alu_x2,
  input  logic [DATA_W-1:0] alu_x3,
  output logic              busy
);

  localparam int         c_CNT_W      = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [2:0] c_OP_RSVD_A  = 3'b010;
  localparam logic [2:0] c_OP_RSVD_B  = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                r_owner;        // requester owning the current transaction
  logic                r_last_grant;   // loser of the next tie is this requester
  logic [c_CNT_W-1:0]  r_cnt;
  logic                r_rsp_valid;
  logic [DATA_W-1:0]   r_rsp_data;
  logic                r_rsp_err;

  logic                w_gnt0;
  logic                w_gnt1;
  logic [2:0]          w_op_sel;
  logic [DATA_W-1:0]   w_a_sel;
  logic [DATA_W-1:0]   w_b_sel;
  logic                w_op_bad;
  logic                w_rsp_ready;

  assign w_rsp_ready = r_owner ? rsp1_ready : rsp0_ready;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next state, grant selection and opcode screening
  always_comb begin
    w_next   = r_state;
    w_gnt0   = 1'b0;
    w_gnt1   = 1'b0;
    w_op_sel = req0_op;
    w_a_sel  = req0_a;
    w_b_sel  = req0_b;
    w_op_bad = 1'b0;
    case (r_state)
      S_IDLE: begin
        // A tie goes to whichever requester was not granted last time
        w_gnt0 = req0_valid & (~req1_valid | r_last_grant);
        w_gnt1 = req1_valid & (~req0_valid | ~r_last_grant);
        if (w_gnt1) begin
          w_op_sel = req1_op;
          w_a_sel  = req1_a;
          w_b_sel  = req1_b;
        end
        w_op_bad = (w_op_sel == c_OP_RSVD_A) || (w_op_sel == c_OP_RSVD_B);
        if (w_gnt0 | w_gnt1) w_next = w_op_bad ? S_RESP : S_ISSUE;
      end
      S_ISSUE: w_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_next = S_RESP;
      S_RESP:  if (r_rsp_valid & w_rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand registers, latency counter and response capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_cnt        <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_data   <= '0;
      r_rsp_err    <= 1'b0;
      alu_op       <= 3'b000;
      alu_x1       <= '0;
      alu_x2       <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_gnt0 | w_gnt1) begin
            r_owner      <= w_gnt1;
            r_last_grant <= w_gnt1;
            if (w_op_bad) begin
              // ALU registers deliberately untouched for rejected opcodes
              r_rsp_data <= '0;
              r_rsp_err  <= 1'b1;
            end else begin
              alu_op <= w_op_sel;
              alu_x1 <= w_a_sel;
              alu_x2 <= w_b_sel;
            end
          end
        end
        S_ISSUE: r_cnt <= c_CNT_W'(ALU_LAT - 1);
        S_WAIT: begin
          if (r_cnt == '0) begin
            r_rsp_data <= alu_x3;
            r_rsp_err  <= 1'b0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_RESP: begin
          // Valid rises one cycle after entering RESP and drops on handshake
          if (!r_rsp_valid)     r_rsp_valid <= 1'b1;
          else if (w_rsp_ready) r_rsp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign rsp0_valid = r_rsp_valid & ~r_owner;
  assign rsp1_valid = r_rsp_valid &  r_owner;
  assign rsp0_data  = r_rsp_data;
  assign rsp1_data  = r_rsp_data;
  assign rsp0_err   = r_rsp_err;
  assign rsp1_err   = r_rsp_err;
  assign busy       = (r_state != S_IDLE);

endmodule
`default_nettype wire
